// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encodings and screen constants for the game blocks
package game_pkg;
    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_HIT       = 2'd1,
        ST_GAME_OVER = 2'd2
    } game_state_t;
    localparam int MAX_X = 640;
    localparam int MAX_Y = 480;
    localparam logic [11:0] SPRITE_BG = 12'h6DE;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-clk frame_end pulse on the rising edge of (x == 0 && y == MAX_Y)
//   clk, reset : clock, synchronous active-high reset
//   x, y       : current VGA pixel position
//   frame_end  : registered pulse, one clk after the pixel first reaches (0, MAX_Y)
module frame_tick_gen #(
    parameter int MAX_Y = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       frame_end
);
    logic at_end;
    logic at_end_q;
    assign at_end = (x == 10'd0) && (y == 10'(MAX_Y));
    // at_end_q resets high so a pixel parked at frame end during reset does not fire
    always_ff @(posedge clk) begin
        if (reset) begin
            at_end_q  <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            at_end_q  <= at_end;
            frame_end <= at_end && !at_end_q;
        end
    end
endmodule

// File: rtl/ghost_collision.sv
// ghost_collision: per-pixel Yoshi/ghost collision latch plus lives/invulnerability FSM
//   clk, reset  : clock, synchronous active-high reset
//   x, y        : current VGA pixel position
//   yoshi_on    : Yoshi opaque pixel at (x, y)
//   ghost_on    : per-ghost opaque pixel at (x, y)
//   restart     : level, leaves GAME_OVER
//   lives       : remaining lives
//   hit_pulse   : one clk when a life is lost
//   ghost_reset : one clk, ghosts return to start positions
//   yoshi_blank : suppress Yoshi's pixels (invulnerability flash)
//   game_over   : high in GAME_OVER
//   state       : FSM state for debug / HUD
module ghost_collision
    import game_pkg::*;
#(
    parameter int NUM_GHOSTS  = 3,
    parameter int START_LIVES = 3,
    parameter int INV_FRAMES  = 120,
    parameter int MAX_Y       = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  yoshi_on,
    input  logic [NUM_GHOSTS-1:0] ghost_on,
    input  logic                  restart,
    output logic [1:0]            lives,
    output logic                  hit_pulse,
    output logic                  ghost_reset,
    output logic                  yoshi_blank,
    output logic                  game_over,
    output logic [1:0]            state
);
    game_state_t state_q, state_n;
    logic [1:0]  lives_n;
    logic [7:0]  inv_cnt, inv_n;
    logic        hit_latch, latch_n;
    logic        hit_n, grst_n, blank_n, go_n;
    logic        frame_end;
    logic        overlap;
    logic        hit_now;

    frame_tick_gen #(.MAX_Y(MAX_Y)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .frame_end (frame_end)
    );

    assign overlap = yoshi_on && |ghost_on;
    // an overlap on the frame_end cycle itself still belongs to the ending frame
    assign hit_now = hit_latch || overlap;
    assign state   = state_q;

    always_comb begin
        state_n = state_q;
        lives_n = lives;
        inv_n   = inv_cnt;
        hit_n   = 1'b0;
        grst_n  = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (frame_end && hit_now && lives != 2'd0) begin
                    hit_n   = 1'b1;
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_n = ST_GAME_OVER;
                    end else begin
                        state_n = ST_HIT;
                        inv_n   = 8'(INV_FRAMES);
                        grst_n  = 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (frame_end) begin
                    inv_n   = inv_cnt - 8'd1;
                    state_n = (inv_cnt == 8'd1) ? ST_PLAY : ST_HIT;
                end
            end
            ST_GAME_OVER: begin
                // restart wins over a coincident frame_end
                if (restart) begin
                    state_n = ST_PLAY;
                    lives_n = 2'(START_LIVES);
                    grst_n  = 1'b1;
                end
            end
            default: state_n = ST_PLAY;
        endcase
        latch_n = (state_q == ST_PLAY && !frame_end) ? hit_now : 1'b0;
        blank_n = (state_n == ST_HIT) && inv_n[3];
        go_n    = state_n == ST_GAME_OVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            lives       <= 2'(START_LIVES);
            inv_cnt     <= 8'd0;
            hit_latch   <= 1'b0;
            hit_pulse   <= 1'b0;
            ghost_reset <= 1'b0;
            yoshi_blank <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_n;
            lives       <= lives_n;
            inv_cnt     <= inv_n;
            hit_latch   <= latch_n;
            hit_pulse   <= hit_n;
            ghost_reset <= grst_n;
            yoshi_blank <= blank_n;
            game_over   <= go_n;
        end
    end
endmodule
